// File: rtl/svfloat.sv
// rtl/svfloat.sv - float field layouts shared by the svfloat arithmetic blocks
package svfloat;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float32;

    typedef struct packed {
        logic        sign;
        logic [4:0]  exponent;
        logic [9:0]  mantissa;
    } float16;

endpackage

// File: rtl/svfloat_muldiv.sv
// rtl/svfloat_muldiv.sv - fixed-latency float multiplier/divider, subnormals flushed, truncating
import svfloat::*;

module svfloat_muldiv #(
    parameter type   float        = float32,
    parameter string mode         = "mul",
    parameter int    plr_pre_mul  = 0,
    parameter int    plr_post_mul = 0
) (
    input  logic clk,
    input  float lhs,
    input  float rhs,
    output float result
);

    localparam int            ew   = $bits(lhs.exponent);
    localparam int            mw   = $bits(lhs.mantissa);
    localparam int            fw   = $bits(float);
    localparam logic [ew-1:0] emax = '1;
    localparam logic [ew+1:0] bias = (ew+2)'((1 << (ew - 1)) - 1);

    float a, b, r_comb;

    if (plr_pre_mul == 0) begin : g_pre_none
        assign a = lhs;
        assign b = rhs;
    end else begin : g_pre
        logic [plr_pre_mul-1:0][2*fw-1:0] pipe;
        // Operand pairs shift through the input stages; data only, never reset
        always_ff @(posedge clk) begin
            pipe[0] <= {lhs, rhs};
            for (int i = 1; i < plr_pre_mul; i++) pipe[i] <= pipe[i-1];
        end
        assign {a, b} = pipe[plr_pre_mul-1];
    end

    // Zero exponent is treated as zero, which flushes subnormal inputs
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    assign a_zero = (a.exponent == '0);
    assign b_zero = (b.exponent == '0);
    assign a_inf  = (a.exponent == emax) && (a.mantissa == '0);
    assign b_inf  = (b.exponent == emax) && (b.mantissa == '0);
    assign a_nan  = (a.exponent == emax) && (a.mantissa != '0);
    assign b_nan  = (b.exponent == emax) && (b.mantissa != '0);

    logic [mw:0]   ma, mb;
    logic [ew+1:0] ea, eb;
    assign ma = {1'b1, a.mantissa};
    assign mb = {1'b1, b.mantissa};
    assign ea = {2'b00, a.exponent};
    assign eb = {2'b00, b.exponent};

    logic [ew+1:0] e_norm;
    logic [mw-1:0] m_norm;
    logic          sp_nan, sp_inf, sp_zero;

    if (mode == "div") begin : g_div
        logic [2*mw+2:0] num, den, q;
        logic            unused_q;
        assign num      = {ma, {(mw+2){1'b0}}};
        assign den      = {{(mw+2){1'b0}}, mb};
        assign q        = num / den;
        // Quotient lies in (0.5, 2); bit mw+2 set means ma >= mb
        assign m_norm   = q[mw+2] ? q[mw+1:2] : q[mw:1];
        assign e_norm   = ea - eb + bias - {{(ew+1){1'b0}}, ~q[mw+2]};
        assign sp_nan   = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
        assign sp_inf   = a_inf | b_zero;
        assign sp_zero  = a_zero | b_inf;
        assign unused_q = ^{q[2*mw+2:mw+3], q[0]};
    end else begin : g_mul
        logic [2*mw+1:0] prod;
        logic            unused_prod;
        assign prod        = {{(mw+1){1'b0}}, ma} * {{(mw+1){1'b0}}, mb};
        // Product lies in [1, 4); top bit set needs one extra exponent step
        assign m_norm      = prod[2*mw+1] ? prod[2*mw:mw+1] : prod[2*mw-1:mw];
        assign e_norm      = ea + eb - bias + {{(ew+1){1'b0}}, prod[2*mw+1]};
        assign sp_nan      = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
        assign sp_inf      = a_inf | b_inf;
        assign sp_zero     = a_zero | b_zero;
        assign unused_prod = ^prod[mw-1:0];
    end

    logic under, over;
    assign under = e_norm[ew+1] || (e_norm == '0);
    assign over  = (e_norm[ew:0] >= {1'b0, emax});

    // Special operands dominate; otherwise saturate to inf or flush to zero on range exit
    always_comb begin
        r_comb      = '0;
        r_comb.sign = a.sign ^ b.sign;
        if (sp_nan) begin
            r_comb.sign     = 1'b0;
            r_comb.exponent = emax;
            r_comb.mantissa = {1'b1, {(mw-1){1'b0}}};
        end else if (sp_inf || (!sp_zero && !under && over)) begin
            r_comb.exponent = emax;
        end else if (!sp_zero && !under) begin
            r_comb.exponent = e_norm[ew-1:0];
            r_comb.mantissa = m_norm;
        end
    end

    if (plr_post_mul == 0) begin : g_post_none
        assign result = r_comb;
    end else begin : g_post
        logic [plr_post_mul-1:0][fw-1:0] pipe;
        // Results shift through the output stages; data only, never reset
        always_ff @(posedge clk) begin
            pipe[0] <= r_comb;
            for (int i = 1; i < plr_post_mul; i++) pipe[i] <= pipe[i-1];
        end
        assign result = pipe[plr_post_mul-1];
    end

endmodule

// File: rtl/svfloat_rr_arbiter.sv
// rtl/svfloat_rr_arbiter.sv - combinational round-robin grant search starting at ptr
module svfloat_rr_arbiter #(
    parameter int  n  = 4,
    localparam int iw = (n > 1) ? $clog2(n) : 1
) (
    input  logic [n-1:0]  req,
    input  logic [iw-1:0] ptr,
    output logic [n-1:0]  grant_onehot,
    output logic [iw-1:0] grant_idx,
    output logic          any
);

    logic [iw-1:0] cand;

    // First requesting index at or after ptr, wrapping at n
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        cand         = '0;
        for (int k = 0; k < n; k++) begin
            cand = iw'((int'(ptr) + k) % n);
            if (!any && req[cand]) begin
                any                = 1'b1;
                grant_idx          = cand;
                grant_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/svfloat_muldiv_arbiter.sv
// rtl/svfloat_muldiv_arbiter.sv - round-robin share of one svfloat_muldiv with tagged result FIFO; SVFLOAT_MULDIV_ARB_STATS_EN adds counters
import svfloat::*;

module svfloat_muldiv_arbiter #(
    parameter type   float        = float32,
    parameter string mode         = "mul",
    parameter int    n_req        = 4,
    parameter int    plr_pre_mul  = 0,
    parameter int    plr_post_mul = 0,
    parameter int    fifo_depth   = 4,
    localparam int   fw           = $bits(float),
    localparam int   tag_width    = (n_req > 1) ? $clog2(n_req) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [n_req-1:0]     req_valid,
    output logic [n_req-1:0]     req_ready,
    input  logic [n_req*fw-1:0]  req_lhs,
    input  logic [n_req*fw-1:0]  req_rhs,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [fw-1:0]        res_data,
    output logic [tag_width-1:0] res_tag
`ifdef SVFLOAT_MULDIV_ARB_STATS_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_stalled
`endif
);

    localparam int L     = plr_pre_mul + plr_post_mul;
    localparam int cnt_w = $clog2(fifo_depth + 1);
    localparam int aw    = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;

    logic [tag_width-1:0]    ptr, grant_idx, push_tag;
    logic [n_req-1:0]        grant_onehot;
    logic                    any_req, can_issue, issue, push, pop;
    logic [cnt_w-1:0]        inflight_cnt, fifo_cnt;
    logic [aw-1:0]           wr_ptr, rd_ptr;
    logic [fw+tag_width-1:0] mem [fifo_depth];
    float                    unit_lhs, unit_rhs, unit_res;

    svfloat_rr_arbiter #(.n(n_req)) u_arb (
        .req          (req_valid),
        .ptr          (ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (any_req)
    );

    // Credits come from registered counts only: a slot freed by a pop is usable next cycle
    assign can_issue = ({1'b0, inflight_cnt} + {1'b0, fifo_cnt}) < (cnt_w+1)'(fifo_depth);
    assign req_ready = rst ? '0 : (grant_onehot & {n_req{can_issue}});
    assign issue     = any_req && can_issue && !rst;

    // Unit sees zero operands on idle cycles
    assign unit_lhs = issue ? float'(req_lhs[grant_idx*fw +: fw]) : '0;
    assign unit_rhs = issue ? float'(req_rhs[grant_idx*fw +: fw]) : '0;

    svfloat_muldiv #(
        .float        (float),
        .mode         (mode),
        .plr_pre_mul  (plr_pre_mul),
        .plr_post_mul (plr_post_mul)
    ) u_unit (
        .clk    (clk),
        .lhs    (unit_lhs),
        .rhs    (unit_rhs),
        .result (unit_res)
    );

    if (L == 0) begin : g_tag_direct
        assign push     = issue;
        assign push_tag = grant_idx;
    end else begin : g_tag_pipe
        logic [L-1:0]                sr_valid;
        logic [L-1:0][tag_width-1:0] sr_tag;
        // Issue marker travels alongside the unit; clearing it on reset hides stale unit output
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sr_valid <= '0;
                sr_tag   <= '0;
            end else begin
                sr_valid[0] <= issue;
                sr_tag[0]   <= grant_idx;
                for (int i = 1; i < L; i++) begin
                    sr_valid[i] <= sr_valid[i-1];
                    sr_tag[i]   <= sr_tag[i-1];
                end
            end
        end
        assign push     = sr_valid[L-1];
        assign push_tag = sr_tag[L-1];
    end

    assign res_valid           = (fifo_cnt != '0);
    assign pop                 = res_valid && res_ready;
    assign {res_tag, res_data} = mem[rd_ptr];

    // Round-robin pointer advances past the requester just served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (grant_idx == tag_width'(n_req - 1)) ? '0 : grant_idx + tag_width'(1);
        end
    end

    // Credits held by results issued but not yet pushed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_cnt <= '0;
        end else if (issue && !push) begin
            inflight_cnt <= inflight_cnt + cnt_w'(1);
        end else if (push && !issue) begin
            inflight_cnt <= inflight_cnt - cnt_w'(1);
        end
    end

    // Circular buffer pointers and occupancy; push and pop may coincide even when full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == aw'(fifo_depth - 1)) ? '0 : wr_ptr + aw'(1);
            if (pop)  rd_ptr <= (rd_ptr == aw'(fifo_depth - 1)) ? '0 : rd_ptr + aw'(1);
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + cnt_w'(1);
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - cnt_w'(1);
            end
        end
    end

    // Result storage; only entries between the read and write pointers are meaningful
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {push_tag, unit_res};
    end

    // The unit cannot stall, so a push into a full FIFO without a pop would lose a result
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_cnt == cnt_w'(fifo_depth))));

`ifdef SVFLOAT_MULDIV_ARB_STATS_EN
    // Issue count and cycles where someone waited but nothing issued; both wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued  <= '0;
            stat_stalled <= '0;
        end else begin
            if (issue) stat_issued <= stat_issued + 32'd1;
            if ((|req_valid) && !issue) stat_stalled <= stat_stalled + 32'd1;
        end
    end
`endif

endmodule
